// File: rtl/fft_pkg.sv
// Shared types for the FFT output streaming stage: FSM states, the sample
// record carried through the output FIFO, and the address-issue rule.
package fft_pkg;

    localparam int FFT_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_ACK  = 2'd2
    } fsm_state_t;

    typedef struct packed {
        logic signed [FFT_DATA_WIDTH-1:0] re;
        logic signed [FFT_DATA_WIDTH-1:0] im;
        logic                             sop;
        logic                             eop;
    } fft_sample_t;

    // A read may be issued only if, after this cycle's pop, the samples already
    // buffered plus the one still in flight leave room in the 2-entry FIFO.
    function automatic logic can_issue(input logic [1:0] occ,
                                       input logic       in_flight,
                                       input logic       pop);
        return ({1'b0, occ} + {2'b00, in_flight}) < (3'd2 + {2'b00, pop});
    endfunction

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry FIFO built as a head register plus a skid register. The head
// register drives the outputs directly, so the presented sample is held
// stable while the consumer stalls.
module skid_fifo2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             sclr_n,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic [1:0]       o_count
);

    logic             r_head_valid;
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_skid;
    logic             w_pop;
    logic             w_head_free;

    assign w_pop       = r_head_valid & i_rd_ready;
    assign w_head_free = ~r_head_valid | w_pop;

    // Occupancy flags: head refills from skid first, then from the write port.
    always_ff @(posedge clk) begin
        if (!sclr_n) begin
            r_head_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_head_free) begin
            r_head_valid <= r_skid_valid | i_wr_en;
            r_skid_valid <= r_skid_valid & i_wr_en;
        end else begin
            r_head_valid <= 1'b1;
            r_skid_valid <= r_skid_valid | i_wr_en;
        end
    end

    // Payload registers carry no reset; their validity is tracked above.
    always_ff @(posedge clk) begin
        if (w_head_free) begin
            r_head <= r_skid_valid ? r_skid : i_wr_data;
            r_skid <= i_wr_data;
        end else if (!r_skid_valid) begin
            r_skid <= i_wr_data;
        end else begin
            r_skid <= r_skid;
        end
    end

    assign o_valid = r_head_valid;
    assign o_data  = r_head;
    assign o_count = {1'b0, r_head_valid} + {1'b0, r_skid_valid};

endmodule

// File: rtl/fft_stream_out.sv
// Streams one frame of N complex samples out of an upstream buffer with a
// registered read port, through a 2-entry FIFO, to a ready/valid consumer.
// The issue rule keeps buffered plus in-flight samples within the FIFO depth.
module fft_stream_out
    import fft_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         sclr_n,
    input  logic                         sink_ready,
    output logic [ADDR_WIDTH-1:0]        sink_rdaddr,
    input  logic signed [DATA_WIDTH-1:0] sink_Re,
    input  logic signed [DATA_WIDTH-1:0] sink_Im,
    output logic                         sink_rdack,
    output logic signed [DATA_WIDTH-1:0] source_Re,
    output logic signed [DATA_WIDTH-1:0] source_Im,
    output logic                         source_valid,
    output logic                         source_sop,
    output logic                         source_eop,
    input  logic                         source_ready,
    output logic                         error
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

    typedef struct packed {
        logic signed [DATA_WIDTH-1:0] re;
        logic signed [DATA_WIDTH-1:0] im;
        logic                         sop;
        logic                         eop;
    } sample_t;

    fsm_state_t            r_state;
    fsm_state_t            w_next_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] w_next_addr;
    logic [ADDR_WIDTH-1:0] r_flight_addr;
    logic                  r_in_flight;
    logic                  r_rdack;
    logic                  r_error;
    logic                  w_issue;
    logic                  w_err;
    logic                  w_pop;
    logic                  w_fifo_valid;
    logic [1:0]            w_fifo_count;
    sample_t               w_wr_data;
    sample_t               w_head;

    assign w_pop = w_fifo_valid & source_ready;

    // Next-state, read-address and protocol-error decode.
    always_comb begin
        w_next_state = r_state;
        w_next_addr  = r_addr;
        w_issue      = 1'b0;
        w_err        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (sink_ready) begin
                    w_next_state = ST_READ;
                    w_next_addr  = '0;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_READ: begin
                w_err = ~sink_ready;
                if (can_issue(w_fifo_count, r_in_flight, w_pop)) begin
                    w_issue = 1'b1;
                    if (r_addr == LAST_ADDR) begin
                        w_next_state = ST_ACK;
                    end else begin
                        w_next_addr = r_addr + ADDR_WIDTH'(1);
                    end
                end else begin
                    w_next_state = ST_READ;
                end
            end
            ST_ACK: begin
                w_err        = ~sink_ready;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State, address counter, in-flight tracking and pulse outputs.
    always_ff @(posedge clk) begin
        if (!sclr_n) begin
            r_state       <= ST_IDLE;
            r_addr        <= '0;
            r_in_flight   <= 1'b0;
            r_flight_addr <= '0;
            r_rdack       <= 1'b0;
            r_error       <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_addr      <= w_next_addr;
            r_in_flight <= w_issue;
            r_rdack     <= w_issue & (r_addr == LAST_ADDR);
            r_error     <= w_err;
            if (w_issue) begin
                r_flight_addr <= r_addr;
            end else begin
                r_flight_addr <= r_flight_addr;
            end
        end
    end

    // Returning read data is tagged with frame-boundary flags from its index.
    always_comb begin
        w_wr_data.re  = sink_Re;
        w_wr_data.im  = sink_Im;
        w_wr_data.sop = (r_flight_addr == '0);
        w_wr_data.eop = (r_flight_addr == LAST_ADDR);
    end

    skid_fifo2 #(
        .WIDTH($bits(sample_t))
    ) u_fifo (
        .clk        (clk),
        .sclr_n     (sclr_n),
        .i_wr_en    (r_in_flight),
        .i_wr_data  (w_wr_data),
        .i_rd_ready (source_ready),
        .o_valid    (w_fifo_valid),
        .o_data     (w_head),
        .o_count    (w_fifo_count)
    );

    assign sink_rdaddr  = r_addr;
    assign sink_rdack   = r_rdack;
    assign error        = r_error;
    assign source_valid = w_fifo_valid;
    assign source_Re    = w_head.re;
    assign source_Im    = w_head.im;
    assign source_sop   = w_head.sop & w_fifo_valid;
    assign source_eop   = w_head.eop & w_fifo_valid;

endmodule

// File: tb/tb_fft_stream_out.sv
// Bench for fft_stream_out with N=8: an upstream ramp buffer, a queue of the
// samples each started frame must deliver, and a per-cycle compare process.
module tb_fft_stream_out;
    import fft_pkg::*;

    localparam int AW = 3;
    localparam int N  = 8;
    localparam int DW = 32;

    logic                 clk = 1'b0;
    logic                 sclr_n;
    logic                 sink_ready;
    logic [AW-1:0]        sink_rdaddr;
    logic signed [DW-1:0] sink_Re;
    logic signed [DW-1:0] sink_Im;
    logic                 sink_rdack;
    logic signed [DW-1:0] source_Re;
    logic signed [DW-1:0] source_Im;
    logic                 source_valid;
    logic                 source_sop;
    logic                 source_eop;
    logic                 source_ready;
    logic                 error;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int pop_total = 0;
    int rdack_total = 0;
    int err_total = 0;
    int last_eop_cyc = -100;
    int last_gap = 0;
    int ready_mode = 0;
    int tick = 0;
    fft_sample_t exp_q[$];
    fft_sample_t prev_s;
    bit          prev_stall = 1'b0;

    always #5 clk = ~clk;

    fft_stream_out #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .sclr_n(sclr_n), .sink_ready(sink_ready),
        .sink_rdaddr(sink_rdaddr), .sink_Re(sink_Re), .sink_Im(sink_Im),
        .sink_rdack(sink_rdack), .source_Re(source_Re), .source_Im(source_Im),
        .source_valid(source_valid), .source_sop(source_sop),
        .source_eop(source_eop), .source_ready(source_ready), .error(error)
    );

    function automatic logic signed [DW-1:0] ramp_re(input logic [AW-1:0] a);
        return $signed({{(DW-AW){1'b0}}, a});
    endfunction

    function automatic logic signed [DW-1:0] ramp_im(input logic [AW-1:0] a);
        return -(32'sd5 * ramp_re(a) + 32'sd1);
    endfunction

    // upstream buffer with a registered read port
    always @(posedge clk) begin
        sink_Re <= ramp_re(sink_rdaddr);
        sink_Im <= ramp_im(sink_rdaddr);
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input bit ok, input longint act, input longint exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // compare process: every pop must match the next expected sample
    initial begin
        fft_sample_t e;
        forever begin
            @(negedge clk);
            if (!sclr_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_hold", source_valid && source_Re == prev_s.re &&
                          source_Im == prev_s.im && source_sop == prev_s.sop &&
                          source_eop == prev_s.eop, source_Re, prev_s.re);
                end
                if (source_valid && source_ready) begin
                    if (exp_q.size() == 0) begin
                        check("extra_sample", 1'b0, source_Re, -1);
                    end else begin
                        e = exp_q.pop_front();
                        check("pop_re", source_Re == e.re, source_Re, e.re);
                        check("pop_im", source_Im == e.im, source_Im, e.im);
                        check("pop_flags", {source_sop, source_eop} == {e.sop, e.eop},
                              {source_sop, source_eop}, {e.sop, e.eop});
                    end
                    pop_total++;
                    if (source_sop) last_gap = cyc - last_eop_cyc;
                    if (source_eop) last_eop_cyc = cyc;
                end
                if (sink_rdack) rdack_total++;
                if (error) err_total++;
                prev_stall = source_valid && !source_ready;
                prev_s = '{re: source_Re, im: source_Im, sop: source_sop, eop: source_eop};
            end
        end
    end

    task automatic wait_cycle();
        @(posedge clk);
        #1;
        case (ready_mode)
            1:       source_ready = (tick % 2 == 0);
            2:       source_ready = 1'b0;
            default: source_ready = 1'b1;
        endcase
        tick++;
    endtask

    task automatic push_frame();
        fft_sample_t e;
        for (int k = 0; k < N; k++) begin
            e.re  = ramp_re(AW'(k));
            e.im  = ramp_im(AW'(k));
            e.sop = (k == 0);
            e.eop = (k == N - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_pops(input int target, input int budget, input string name);
        int k = 0;
        while (pop_total < target && k < budget) begin
            wait_cycle();
            k++;
        end
        check(name, pop_total >= target, pop_total, target);
    endtask

    task automatic wait_rdacks(input int target, input int budget, input string name);
        int k = 0;
        while (rdack_total < target && k < budget) begin
            wait_cycle();
            k++;
        end
        check(name, rdack_total >= target, rdack_total, target);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, source_valid == 1'b0, source_valid, 0);
        check({tag, "_sop_eop"}, {source_sop, source_eop} == 2'b00, {source_sop, source_eop}, 0);
        check({tag, "_rdack"}, sink_rdack == 1'b0, sink_rdack, 0);
        check({tag, "_error"}, error == 1'b0, error, 0);
        check({tag, "_rdaddr"}, sink_rdaddr == '0, sink_rdaddr, 0);
    endtask

    initial begin
        int base;
        int base2;
        int a5;
        int p_stall;
        sclr_n = 1'b0;
        sink_ready = 1'b0;
        source_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1 sclr_n = 1'b1;
        wait_cycle();
        wait_cycle();

        // latency/throughput: sink_ready seen at cycle 0
        push_frame();
        sink_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("lat_valid", source_valid == (i >= 3 && i <= 10), source_valid, (i >= 3 && i <= 10));
            check("lat_rdack", sink_rdack == (i == 9), sink_rdack, (i == 9));
            if (i == 3) check("first_sample", source_sop && source_Re == 0 && source_Im == -1, source_Re, 0);
            if (i == 10) check("last_sample", source_eop && source_Re == 7 && source_Im == -36, source_Re, 7);
            if (i == 9) begin
                @(posedge clk);
                #1 sink_ready = 1'b0;
            end
        end
        repeat (3) wait_cycle();
        check("t1_drained", exp_q.size() == 0, exp_q.size(), 0);
        check("t1_rdack_count", rdack_total == 1, rdack_total, 1);

        // toggled source_ready
        ready_mode = 1;
        tick = 0;
        base = rdack_total;
        base2 = pop_total;
        push_frame();
        sink_ready = 1'b1;
        wait_rdacks(base + 1, 200, "t2_rdack_seen");
        sink_ready = 1'b0;
        repeat (10) wait_cycle();
        check("t2_single_rdack", rdack_total == base + 1, rdack_total, base + 1);
        check("t2_pop_count", pop_total == base2 + N, pop_total - base2, N);
        check("t2_drained", exp_q.size() == 0, exp_q.size(), 0);

        // long consumer stall mid-frame
        ready_mode = 0;
        base = rdack_total;
        base2 = pop_total;
        push_frame();
        sink_ready = 1'b1;
        wait_pops(base2 + 3, 50, "t3_first_pops");
        ready_mode = 2;
        wait_cycle();
        p_stall = pop_total;
        a5 = 0;
        for (int s = 1; s <= 20; s++) begin
            wait_cycle();
            if (s == 5) a5 = int'(sink_rdaddr);
        end
        check("t3_addr_hold", int'(sink_rdaddr) == a5, sink_rdaddr, a5);
        check("t3_no_pops", pop_total == p_stall, pop_total, p_stall);
        check("t3_buffer_bound", int'(sink_rdaddr) <= (pop_total - base2) + 2, sink_rdaddr, (pop_total - base2) + 2);
        ready_mode = 0;
        wait_rdacks(base + 1, 100, "t3_rdack_seen");
        sink_ready = 1'b0;
        repeat (6) wait_cycle();
        check("t3_pop_count", pop_total == base2 + N, pop_total - base2, N);
        check("t3_drained", exp_q.size() == 0, exp_q.size(), 0);
        check("no_spurious_error", err_total == 0, err_total, 0);

        // sink_ready dropped for one cycle at the 4th READ cycle
        base = rdack_total;
        base2 = err_total;
        push_frame();
        sink_ready = 1'b1;
        repeat (4) wait_cycle();
        sink_ready = 1'b0;
        wait_cycle();
        sink_ready = 1'b1;
        wait_rdacks(base + 1, 100, "t4_rdack_seen");
        sink_ready = 1'b0;
        repeat (6) wait_cycle();
        check("t4_error_once", err_total == base2 + 1, err_total - base2, 1);
        check("t4_drained", exp_q.size() == 0, exp_q.size(), 0);

        // reset after 3 samples of a frame
        base2 = pop_total;
        push_frame();
        sink_ready = 1'b1;
        wait_pops(base2 + 3, 50, "t5_first_pops");
        base = rdack_total;
        sclr_n = 1'b0;
        sink_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midreset");
        exp_q.delete();
        @(posedge clk);
        #1 sclr_n = 1'b1;
        repeat (15) wait_cycle();
        check("t5_no_rdack", rdack_total == base, rdack_total, base);
        check("t5_idle_after_reset", source_valid == 1'b0, source_valid, 0);
        push_frame();
        sink_ready = 1'b1;
        for (int i = 0; i < 4; i++) @(negedge clk);
        check("t5_restart_sop", source_valid && source_sop && source_Re == 0, source_Re, 0);
        wait_rdacks(base + 1, 100, "t5_rdack_seen");
        sink_ready = 1'b0;
        repeat (6) wait_cycle();
        check("t5_drained", exp_q.size() == 0, exp_q.size(), 0);

        // two back-to-back frames
        base = rdack_total;
        base2 = pop_total;
        push_frame();
        push_frame();
        sink_ready = 1'b1;
        wait_rdacks(base + 2, 300, "t6_rdacks_seen");
        sink_ready = 1'b0;
        repeat (6) wait_cycle();
        check("t6_pop_count", pop_total == base2 + 2 * N, pop_total - base2, 2 * N);
        check("t6_gap", last_gap >= 1 && last_gap <= 4, last_gap, 4);
        check("t6_drained", exp_q.size() == 0, exp_q.size(), 0);
        check("t6_rdack_count", rdack_total == base + 2, rdack_total - base, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
